// File: rtl/tinyml_display_cfg_pkg.sv
// Shared constants and FSM encoding for the display panel config loader.
package tinyml_display_cfg_pkg;

  localparam int unsigned WORD_W = 40;
  localparam int unsigned ADDR_W = 9;

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] OP_CONFIG = 8'h43;
  localparam logic [7:0] RESP_ACK  = 8'h4B;
  localparam logic [7:0] RESP_NAK  = 8'h4E;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StWrite,
    StRecfg,
    StRdWait,
    StTx,
    StResp
  } state_e;

endpackage

// File: rtl/tinyml_display_cfg_tx_serializer.sv
// Emits a 1- or 5-byte response MSB first on a valid/ready link.
module tinyml_display_cfg_tx_serializer
  import tinyml_display_cfg_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_word,
  input  logic [2:0]        i_count,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_done
);

  logic [WORD_W-1:0] r_shift;
  logic [2:0]        r_left;
  logic              r_valid;
  logic              w_xfer;

  assign w_xfer     = r_valid & i_tx_ready;
  assign o_done     = w_xfer & (r_left == 3'd1);
  assign o_tx_valid = r_valid;
  assign o_tx_data  = r_shift[WORD_W-1 -: 8];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (i_start) begin
      // A single-byte reply travels in the low byte of i_word; align it to the top.
      r_shift <= (i_count == 3'd1) ? {i_word[7:0], {(WORD_W-8){1'b0}}} : i_word;
      r_left  <= i_count;
      r_valid <= (i_count != 3'd0);
    end else if (w_xfer) begin
      r_shift <= r_shift << 8;
      r_left  <= r_left - 3'd1;
      r_valid <= (r_left != 3'd1);
    end
  end

endmodule

// File: rtl/tinyml_display_panel_cfg_loader.sv
// Host byte-protocol parser driving the panel sequencer's config RAM debug port.
module tinyml_display_panel_cfg_loader
  import tinyml_display_cfg_pkg::*;
#(
  parameter int unsigned RD_LATENCY     = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic              i_axi_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_dbg_we,
  output logic [ADDR_W-1:0] o_dbg_addr,
  output logic [WORD_W-1:0] o_dbg_din,
  input  logic [WORD_W-1:0] i_dbg_dout,
  output logic              o_dbg_reconfig,
  output logic              o_busy,
  output logic              o_err
);

  state_e            r_state, w_state_nxt;
  logic [7:0]        r_cnt;
  logic [23:0]       r_to;
  logic              r_is_wr;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_din;

  logic              w_collect, w_acc, w_expire, w_err;
  logic              w_ser_start, w_ser_done;
  logic [WORD_W-1:0] w_ser_word;
  logic [2:0]        w_ser_cnt;

  assign w_collect      = (r_state == StAddr) || (r_state == StData);
  assign o_rx_ready     = ~i_rst & (w_collect | (r_state == StIdle));
  assign w_acc          = i_rx_valid & o_rx_ready;
  // An accepted byte in the expiry cycle wins over the timeout.
  assign w_expire       = w_collect & ~w_acc & (r_to == TIMEOUT_CYCLES - 24'd1);
  assign o_dbg_we       = (r_state == StWrite);
  assign o_dbg_reconfig = (r_state == StRecfg);
  assign o_busy         = (r_state != StIdle);
  assign o_dbg_addr     = r_addr;
  assign o_dbg_din      = r_din;
  assign o_err          = r_err;

  always_ff @(posedge i_axi_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ser_start = 1'b0;
    w_ser_word  = '0;
    w_ser_cnt   = 3'd1;
    w_err       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_acc) begin
          case (i_rx_data)
            OP_WRITE, OP_READ: w_state_nxt = StAddr;
            OP_CONFIG:         w_state_nxt = StRecfg;
            default: begin
              w_state_nxt = StResp;
              w_ser_start = 1'b1;
              w_ser_word  = {{(WORD_W-8){1'b0}}, RESP_NAK};
              w_err       = 1'b1;
            end
          endcase
        end
      end
      StAddr: begin
        if (w_acc && r_cnt == 8'd1) begin
          w_state_nxt = r_is_wr ? StData : StRdWait;
        end else if (w_expire) begin
          w_state_nxt = StIdle;
          w_err       = 1'b1;
        end
      end
      StData: begin
        if (w_acc && r_cnt == 8'd4) begin
          w_state_nxt = StWrite;
        end else if (w_expire) begin
          w_state_nxt = StIdle;
          w_err       = 1'b1;
        end
      end
      StWrite, StRecfg: begin
        w_state_nxt = StResp;
        w_ser_start = 1'b1;
        w_ser_word  = {{(WORD_W-8){1'b0}}, RESP_ACK};
      end
      StRdWait: begin
        if (r_cnt == 8'(RD_LATENCY)) begin
          w_state_nxt = StTx;
          w_ser_start = 1'b1;
          w_ser_word  = i_dbg_dout;
          w_ser_cnt   = 3'd5;
        end
      end
      StTx, StResp: begin
        if (w_ser_done) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_axi_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_to    <= '0;
      r_is_wr <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      r_err <= w_err;
      // r_cnt counts bytes in ADDR/DATA and wait cycles in RD_WAIT.
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (w_acc || r_state == StRdWait) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (!w_collect || w_acc) begin
        r_to <= '0;
      end else begin
        r_to <= r_to + 24'd1;
      end
      if (w_acc) begin
        case (r_state)
          StIdle: r_is_wr <= (i_rx_data == OP_WRITE);
          StAddr: begin
            if (r_cnt == 8'd0) r_addr[ADDR_W-1] <= i_rx_data[0];
            else               r_addr[7:0]      <= i_rx_data;
          end
          StData:  r_din <= {r_din[WORD_W-9:0], i_rx_data};
          default: ;
        endcase
      end
    end
  end

  tinyml_display_cfg_tx_serializer u_tx_ser (
    .i_clk      (i_axi_clk),
    .i_rst      (i_rst),
    .i_start    (w_ser_start),
    .i_word     (w_ser_word),
    .i_count    (w_ser_cnt),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done     (w_ser_done)
  );

endmodule

// File: tb/tb_tinyml_display_panel_cfg_loader.sv
// Self-checking bench: command-level reference model plus directed timing checks.
module tb_tinyml_display_panel_cfg_loader;

  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h4E;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        dbg_we;
  logic [8:0]  dbg_addr;
  logic [39:0] dbg_din;
  logic [39:0] dbg_dout;
  logic        dbg_reconfig;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  tinyml_display_panel_cfg_loader #(
    .RD_LATENCY     (2),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .i_axi_clk      (clk),
    .i_rst          (rst),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_rx_ready     (rx_ready),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready),
    .o_dbg_we       (dbg_we),
    .o_dbg_addr     (dbg_addr),
    .o_dbg_din      (dbg_din),
    .i_dbg_dout     (dbg_dout),
    .o_dbg_reconfig (dbg_reconfig),
    .o_busy         (busy),
    .o_err          (err)
  );

  function automatic logic [39:0] init_word(input int i);
    if (i == 511) return 40'hA5_0000_0010;
    return {8'(i * 7), 32'hC0DE_0000 | 32'(i)};
  endfunction

  // Config RAM stand-in: registered address, registered data (2-cycle read).
  logic [39:0]  ram [0:511];
  logic [511:0] ram_vld = '0;
  logic [8:0]   ram_a = '0;
  logic [39:0]  ram_q = '0;
  assign dbg_dout = ram_q;
  always @(posedge clk) begin
    if (dbg_we) begin
      ram[dbg_addr]     <= dbg_din;
      ram_vld[dbg_addr] <= 1'b1;
    end
    ram_a <= dbg_addr;
    ram_q <= ram_vld[ram_a] ? ram[ram_a] : init_word(int'(ram_a));
  end

  // Reference model state
  logic [39:0] mem_m [0:511];
  logic [7:0]  cmdq[$];
  logic [7:0]  exp_tx[$];
  logic [48:0] exp_wr[$];
  int          exp_rc = 0;
  int          exp_err = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          tx_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Parses the accepted byte stream into whole commands and their effects.
  function automatic void model_byte(input logic [7:0] b);
    int          len;
    logic [8:0]  a;
    logic [39:0] d;
    cmdq.push_back(b);
    len = (cmdq[0] == 8'h57) ? 8 : (cmdq[0] == 8'h52) ? 3 : 1;
    if (cmdq.size() < len) return;
    a = '0;
    if (len > 1) a = {cmdq[1][0], cmdq[2]};
    case (cmdq[0])
      8'h57: begin
        d = '0;
        for (int i = 3; i < 8; i++) d = {d[31:0], cmdq[i]};
        mem_m[a] = d;
        exp_wr.push_back({a, d});
        exp_tx.push_back(ACK);
      end
      8'h52: begin
        d = mem_m[a];
        for (int i = 4; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
      end
      8'h43: begin
        exp_rc++;
        exp_tx.push_back(ACK);
      end
      default: begin
        exp_err++;
        exp_tx.push_back(NAK);
      end
    endcase
    cmdq.delete();
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 3) != 0);
      default: tx_ready = 1'b0;
    endcase
  end

  // Per-cycle comparison of DUT activity against the model's expectations.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (dbg_we) begin
        check("we_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) check("wr_addr_din", {dbg_addr, dbg_din}, exp_wr.pop_front());
      end
      if (dbg_reconfig) begin
        check("reconfig_expected", exp_rc > 0, 1);
        if (exp_rc > 0) exp_rc--;
      end
      if (err) begin
        check("err_expected", exp_err > 0, 1);
        if (exp_err > 0) exp_err--;
      end
      if (prev_stall) check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
      if (tx_valid) check("rx_ready_low_while_tx", rx_ready, 0);
      if (!busy) check("rx_ready_when_idle", rx_ready, 1);
      if (tx_valid && tx_ready) begin
        check("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) check("tx_byte", tx_data, exp_tx.pop_front());
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    guard = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", rx_ready, 1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_seq(input bq_t q, input int gmax);
    foreach (q[i]) send_byte(q[i], $urandom_range(0, gmax));
  endtask

  task automatic watch(input int n, output int k_we, output int k_rc, output int k_tx,
                       output int k_err);
    k_we = 0; k_rc = 0; k_tx = 0; k_err = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (dbg_we && k_we == 0) k_we = k;
      if (dbg_reconfig && k_rc == 0) k_rc = k;
      if (tx_valid && k_tx == 0) k_tx = k;
      if (err && k_err == 0) k_err = k;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || tx_valid || exp_tx.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int       k_we, k_rc, k_tx, k_err;
    bq_t      q;
    logic [7:0] op;
    int       t, gmax;

    for (int i = 0; i < 512; i++) mem_m[i] = init_word(i);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_ready", rx_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_tx_valid", tx_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", rx_ready, 1);

    // W 57 00 03 11 22 33 44 55
    tx_mode = 0;
    q = '{8'h57, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_seq(q, 0);
    watch(12, k_we, k_rc, k_tx, k_err);
    check("w_we_cycle", k_we, 1);
    check("w_ack_cycle", k_tx, 2);
    wait_idle();
    check("w_addr_held", dbg_addr, 9'h003);
    check("w_din_held", dbg_din, 40'h11_2233_4455);

    // R 52 01 FF with a long tx stall
    tx_mode = 2;
    q = '{8'h52, 8'h01, 8'hFF};
    send_seq(q, 0);
    watch(20, k_we, k_rc, k_tx, k_err);
    check("r_first_byte_cycle", k_tx, 4);
    check("r_stalled_first_byte", {tx_valid, tx_data}, {1'b1, 8'hA5});
    tx_mode = 0;
    wait_idle();

    // C 43
    q = '{8'h43};
    send_seq(q, 0);
    watch(10, k_we, k_rc, k_tx, k_err);
    check("c_reconfig_cycle", k_rc, 1);
    check("c_ack_cycle", k_tx, 2);
    wait_idle();

    // Unknown opcode 7F
    q = '{8'h7F};
    send_seq(q, 0);
    watch(10, k_we, k_rc, k_tx, k_err);
    check("nak_err_seen", k_err != 0, 1);
    check("nak_no_write", k_we, 0);
    check("nak_no_reconfig", k_rc, 0);
    check("nak_tx_cycle", k_tx, 1);
    wait_idle();

    // Timeout after 57 00: partial command dropped silently
    q = '{8'h57, 8'h00};
    send_seq(q, 0);
    exp_err++;
    cmdq.delete();
    watch(20, k_we, k_rc, k_tx, k_err);
    check("to_err_cycle", (k_err == 16) || (k_err == 17), 1);
    check("to_no_tx", k_tx, 0);
    check("to_no_write", k_we, 0);
    check("to_back_idle", busy, 0);
    q = '{8'h52, 8'h00, 8'h03};
    send_seq(q, 0);
    wait_idle();

    // Bytes arriving in the 16th idle cycle do not time out
    send_byte(8'h57, 0);
    send_byte(8'h01, 0);
    send_byte(8'h05, 15);
    send_byte(8'h66, 0);
    send_byte(8'h77, 15);
    send_byte(8'h88, 0);
    send_byte(8'h99, 0);
    send_byte(8'hAA, 15);
    wait_idle();
    check("boundary_addr", dbg_addr, 9'h105);
    check("boundary_din", dbg_din, 40'h66_7788_99AA);

    // Reset in the middle of DATA
    q = '{8'h57, 8'h00, 8'h07, 8'hAA, 8'hBB, 8'hCC};
    send_seq(q, 0);
    rst = 1'b1;
    cmdq.delete();
    @(negedge clk);
    check("rst_mid_outputs",
          {rx_ready, tx_valid, tx_data, dbg_we, dbg_reconfig, busy, err}, '0);
    check("rst_mid_addr_din", {dbg_addr, dbg_din}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q = '{8'h57, 8'h01, 8'h23, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    send_seq(q, 3);
    wait_idle();
    check("post_rst_write_din", dbg_din, 40'hDE_ADBE_EF01);

    // Randomized command mix
    tx_mode = 1;
    for (int n = 0; n < 40; n++) begin
      q.delete();
      t    = $urandom_range(0, 3);
      gmax = ($urandom_range(0, 1) != 0) ? 15 : 2;
      case (t)
        0: begin
          q.push_back(8'h57);
          repeat (7) q.push_back(8'($urandom));
        end
        1: begin
          q.push_back(8'h52);
          repeat (2) q.push_back(8'($urandom));
        end
        2: q.push_back(8'h43);
        default: begin
          op = 8'($urandom);
          while (op == 8'h57 || op == 8'h52 || op == 8'h43) op = 8'($urandom);
          q.push_back(op);
        end
      endcase
      send_seq(q, gmax);
      wait_idle();
    end

    tx_mode = 0;
    wait_idle();
    check("end_tx_drained", exp_tx.size(), 0);
    check("end_writes_drained", exp_wr.size(), 0);
    check("end_reconfig_drained", exp_rc, 0);
    check("end_err_drained", exp_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
